// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq
//   Multi-cycle floating-point adder/subtractor. One operation walks through
//   ALIGN -> ADD -> NORM -> ROUND and reports on a one-cycle done pulse.
//   Inputs with a zero exponent are flushed to zero; subnormals are never
//   produced. Infinite/NaN inputs and exponent overflow saturate to infinity.
//
// Configuration macro:
//   FP_ADDSUB_RNE_EN  defined  -> ROUND applies round-to-nearest-even
//                     undefined -> ROUND truncates (same 4-cycle latency)
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   operation request, accepted only when idle
//   mode      in   0 = op1+op2, 1 = op1-op2
//   op1, op2  in   operands {sign, exp, man}
//   busy      out  operation in flight (through the done cycle)
//   done      out  one-cycle pulse, result/flags valid
//   result    out  sum/difference, held until the next done
//   overflow  out  result saturated to infinity or an input was inf/NaN
//   zero      out  result is +0
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   mode,
  input  logic [EXP_W+MAN_W:0]   op1,
  input  logic [EXP_W+MAN_W:0]   op2,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow,
  output logic                   zero
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int FW = MAN_W + 1;   // mantissa including hidden bit
  localparam int XW = FW + 3;      // mantissa plus guard, round, sticky
  localparam int EW = EXP_W + 2;   // signed working exponent
  localparam logic [EXP_W-1:0]        EXP_ONES = '1;
  localparam logic signed [EW-1:0]    EXP_MAX  = {2'b00, {EXP_W{1'b1}}};

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND} state_t;
  state_t state, state_next;

  logic                    sa, sb;
  logic [EXP_W-1:0]        ea, eb;
  logic [MAN_W-1:0]        ma, mb;
  logic                    sign_r, sub_r, special_r, mag_zero_r;
  logic signed [EW-1:0]    exp_r;
  logic [FW-1:0]           big_r;
  logic [XW-1:0]           small_r;
  logic [XW:0]             sum_r;
  logic [XW-1:0]           norm_r;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Fixed walk through the four stages once a start is accepted
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ALIGN;
      ALIGN:   state_next = ADD;
      ADD:     state_next = NORM;
      NORM:    state_next = ROUND;
      ROUND:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE) || done;

  // Alignment: order operands by magnitude, then shift the smaller one right
  // keeping guard and round bits and OR-ing everything below into sticky.
  logic               a_ge_b;
  logic [EXP_W-1:0]   ex_big, ex_small, diff;
  logic [FW-1:0]      mant_big, mant_small;
  logic [2*FW+1:0]    shift_wide;
  logic [XW-1:0]      small_aligned;
  always_comb begin
    a_ge_b     = {ea, ma} >= {eb, mb};
    ex_big     = a_ge_b ? ea : eb;
    ex_small   = a_ge_b ? eb : ea;
    mant_big   = a_ge_b ? {ea != '0, ma} : {eb != '0, mb};
    mant_small = a_ge_b ? {eb != '0, mb} : {ea != '0, ma};
    diff       = ex_big - ex_small;
    shift_wide = {mant_small, {(FW+2){1'b0}}} >> diff;
    if (int'(diff) > MAN_W + 2)
      small_aligned = {{(XW-1){1'b0}}, |mant_small};
    else
      small_aligned = {shift_wide[2*FW+1:FW], |shift_wide[FW-1:0]};
  end

  // Leading-zero count of the non-carry sum; highest set bit wins
  int lzc;
  always_comb begin
    lzc = XW;
    for (int i = 0; i < XW; i++)
      if (sum_r[i]) lzc = XW - 1 - i;
  end

  // Rounding and the final special-case decision
  logic                  inc;
  logic [FW:0]           rounded;
  logic signed [EW-1:0]  exp_fin;
  logic [MAN_W-1:0]      mant_fin;
  logic [W-1:0]          res_next;
  logic                  ovf_next, zero_next;
  always_comb begin
`ifdef FP_ADDSUB_RNE_EN
    inc = norm_r[2] & (norm_r[1] | norm_r[0] | norm_r[3]);
`else
    inc = 1'b0;
`endif
    rounded  = {1'b0, norm_r[XW-1:3]} + {{FW{1'b0}}, inc};
    exp_fin  = exp_r;
    mant_fin = rounded[MAN_W-1:0];
    if (rounded[FW]) begin
      exp_fin  = exp_r + EW'(1);
      mant_fin = rounded[MAN_W:1];
    end
    res_next  = '0;
    ovf_next  = 1'b0;
    zero_next = 1'b0;
    if (special_r) begin
      res_next = {sign_r, EXP_ONES, {MAN_W{1'b0}}};
      ovf_next = 1'b1;
    end else if (mag_zero_r || exp_fin[EW-1] || exp_fin == '0) begin
      zero_next = 1'b1;
    end else if (exp_fin >= EXP_MAX) begin
      res_next = {sign_r, EXP_ONES, {MAN_W{1'b0}}};
      ovf_next = 1'b1;
    end else begin
      res_next = {sign_r, exp_fin[EXP_W-1:0], mant_fin};
    end
  end

`ifndef FP_ADDSUB_RNE_EN
  // Guard/round/sticky are still carried through NORM but discarded here
  logic unused_grs;
  assign unused_grs = ^norm_r[2:0];
`endif

  // Datapath: each state loads the registers for the following stage.
  // Operand 2's sign is flipped at capture so the rest is a plain add.
  always_ff @(posedge clk) begin
    if (rst) begin
      done     <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sa <= op1[W-1];
          ea <= op1[W-2 -: EXP_W];
          ma <= (op1[W-2 -: EXP_W] == '0) ? '0 : op1[MAN_W-1:0];
          sb <= op2[W-1] ^ mode;
          eb <= op2[W-2 -: EXP_W];
          mb <= (op2[W-2 -: EXP_W] == '0) ? '0 : op2[MAN_W-1:0];
        end
        ALIGN: begin
          sign_r    <= a_ge_b ? sa : sb;
          sub_r     <= sa ^ sb;
          special_r <= (ea == EXP_ONES) || (eb == EXP_ONES);
          exp_r     <= {2'b00, ex_big};
          big_r     <= mant_big;
          small_r   <= small_aligned;
        end
        ADD: begin
          if (sub_r) sum_r <= {1'b0, big_r, 3'b000} - {1'b0, small_r};
          else       sum_r <= {1'b0, big_r, 3'b000} + {1'b0, small_r};
        end
        NORM: begin
          mag_zero_r <= (sum_r == '0);
          if (sum_r[XW]) begin
            // Carry out: old LSB becomes guard, round/sticky merge into sticky
            norm_r <= {sum_r[XW:2], sum_r[1] | sum_r[0]};
            exp_r  <= exp_r + EW'(1);
          end else begin
            norm_r <= sum_r[XW-1:0] << lzc;
            exp_r  <= exp_r - EW'(lzc);
          end
        end
        ROUND: begin
          result   <= res_next;
          overflow <= ovf_next;
          zero     <= zero_next;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb_fp_addsub_seq
//   Self-checking bench for fp_addsub_seq in single-precision configuration.
//   Expected results are pushed to a scoreboard queue as each operation is
//   issued and popped when the matching done pulse arrives.
module tb_fp_addsub_seq;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int W     = 1 + EXP_W + MAN_W;

`ifdef FP_ADDSUB_RNE_EN
  localparam logic [W-1:0] RND_A = 32'h3F800002;
  localparam logic [W-1:0] RND_B = 32'h3F800001;
  localparam logic [W-1:0] RND_C = 32'h40000000;
`else
  localparam logic [W-1:0] RND_A = 32'h3F800001;
  localparam logic [W-1:0] RND_B = 32'h3F800000;
  localparam logic [W-1:0] RND_C = 32'h3FFFFFFF;
`endif

  logic          clk = 1'b0;
  logic          rst, start, mode;
  logic [W-1:0]  op1, op2, result;
  logic          busy, done, overflow, zero;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic         ovf;
    logic         zro;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         m;
    logic [W-1:0] r;
    logic         o;
    logic         z;
  } vec_t;

  exp_t sb_q[$];

  fp_addsub_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .op1(op1), .op2(op2), .busy(busy), .done(done),
    .result(result), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  // Issue one operation and wait (bounded) for done; operands are scrambled
  // after capture so a design that re-samples them would be caught.
  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic m, output logic got, output int lat);
    @(negedge clk);
    op1 = a; op2 = b; mode = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op1 = $urandom(); op2 = $urandom(); mode = 1'($urandom_range(0, 1));
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin got = 1'b1; break; end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 1'b0; op1 = '0; op2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, overflow, zero, result} !== '0) begin
      errors++;
      $display("[TB] FAIL reset: busy=%b done=%b ovf=%b zero=%b result=%h, expected all 0",
               busy, done, overflow, zero, result);
    end
  endtask

  task automatic test_add();
    vec_t tab[3];
    exp_t e; logic got; int lat;
    tab[0] = '{32'h3FA00000, 32'h3FC00000, 1'b0, 32'h40300000, 1'b0, 1'b0};
    tab[1] = '{32'h3F800000, 32'h3F000000, 1'b0, 32'h3FC00000, 1'b0, 1'b0};
    tab[2] = '{32'h3F800000, 32'hBF000000, 1'b0, 32'h3F000000, 1'b0, 1'b0};
    foreach (tab[i]) begin
      sb_q.push_back('{tab[i].r, tab[i].o, tab[i].z});
      drive_op(tab[i].a, tab[i].b, tab[i].m, got, lat);
      e = sb_q.pop_front();
      checks++;
      if (!got) begin
        errors++;
        $display("[TB] FAIL add_%0d: done not seen within 20 cycles", i);
      end else if ({result, overflow, zero} !== {e.res, e.ovf, e.zro}) begin
        errors++;
        $display("[TB] FAIL add_%0d: got %h ovf=%b zero=%b, expected %h ovf=%b zero=%b",
                 i, result, overflow, zero, e.res, e.ovf, e.zro);
      end
      checks++;
      if (lat != 4 || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL add_latency_%0d: latency=%0d busy=%b, expected latency=4 busy=1",
                 i, lat, busy);
      end
    end
  endtask

  task automatic test_sub();
    vec_t tab[4];
    exp_t e; logic got; int lat;
    tab[0] = '{32'h3FC00000, 32'h3FA00000, 1'b1, 32'h3E800000, 1'b0, 1'b0};
    tab[1] = '{32'h3FA00000, 32'h3FA00000, 1'b1, 32'h00000000, 1'b0, 1'b1};
    tab[2] = '{32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 1'b0, 1'b0};
    tab[3] = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 1'b0};
    foreach (tab[i]) begin
      sb_q.push_back('{tab[i].r, tab[i].o, tab[i].z});
      drive_op(tab[i].a, tab[i].b, tab[i].m, got, lat);
      e = sb_q.pop_front();
      checks++;
      if (!got) begin
        errors++;
        $display("[TB] FAIL sub_%0d: done not seen within 20 cycles", i);
      end else if ({result, overflow, zero} !== {e.res, e.ovf, e.zro}) begin
        errors++;
        $display("[TB] FAIL sub_%0d: got %h ovf=%b zero=%b, expected %h ovf=%b zero=%b",
                 i, result, overflow, zero, e.res, e.ovf, e.zro);
      end
    end
  endtask

  task automatic test_special();
    vec_t tab[5];
    exp_t e; logic got; int lat;
    tab[0] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0};
    tab[1] = '{32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 32'hFF800000, 1'b1, 1'b0};
    tab[2] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b1, 1'b0};
    tab[3] = '{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0};
    tab[4] = '{32'h00800000, 32'h00C00000, 1'b1, 32'h00000000, 1'b0, 1'b1};
    foreach (tab[i]) begin
      sb_q.push_back('{tab[i].r, tab[i].o, tab[i].z});
      drive_op(tab[i].a, tab[i].b, tab[i].m, got, lat);
      e = sb_q.pop_front();
      checks++;
      if (!got) begin
        errors++;
        $display("[TB] FAIL special_%0d: done not seen within 20 cycles", i);
      end else if ({result, overflow, zero} !== {e.res, e.ovf, e.zro}) begin
        errors++;
        $display("[TB] FAIL special_%0d: got %h ovf=%b zero=%b, expected %h ovf=%b zero=%b",
                 i, result, overflow, zero, e.res, e.ovf, e.zro);
      end
    end
  endtask

  task automatic test_rounding();
    vec_t tab[4];
    exp_t e; logic got; int lat;
    tab[0] = '{32'h3F800000, 32'h34400000, 1'b0, RND_A,        1'b0, 1'b0};
    tab[1] = '{32'h3F800000, 32'h33C00000, 1'b0, RND_B,        1'b0, 1'b0};
    tab[2] = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0};
    tab[3] = '{32'h3FFFFFFF, 32'h33C00000, 1'b0, RND_C,        1'b0, 1'b0};
    foreach (tab[i]) begin
      sb_q.push_back('{tab[i].r, tab[i].o, tab[i].z});
      drive_op(tab[i].a, tab[i].b, tab[i].m, got, lat);
      e = sb_q.pop_front();
      checks++;
      if (!got) begin
        errors++;
        $display("[TB] FAIL round_%0d: done not seen within 20 cycles", i);
      end else if ({result, overflow, zero} !== {e.res, e.ovf, e.zro}) begin
        errors++;
        $display("[TB] FAIL round_%0d: got %h ovf=%b zero=%b, expected %h ovf=%b zero=%b",
                 i, result, overflow, zero, e.res, e.ovf, e.zro);
      end
    end
  endtask

  task automatic test_start_ignored();
    exp_t e; int dones = 0; logic seen = 1'b0;
    logic [W+1:0] snap = '0;
    sb_q.push_back('{32'h40300000, 1'b0, 1'b0});
    @(negedge clk);
    op1 = 32'h3FA00000; op2 = 32'h3FC00000; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i == 1) begin
        op1 = 32'h40000000; op2 = 32'h40000000; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dones++;
        if (!seen) begin seen = 1'b1; snap = {result, overflow, zero}; end
      end
      @(negedge clk);
    end
    start = 1'b0;
    e = sb_q.pop_front();
    checks++;
    if (dones != 1) begin
      errors++;
      $display("[TB] FAIL busy_start_done_count: got %0d done pulses, expected 1", dones);
    end
    checks++;
    if (snap !== {e.res, e.ovf, e.zro}) begin
      errors++;
      $display("[TB] FAIL busy_start_result: got %h, expected %h", snap, {e.res, e.ovf, e.zro});
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; logic got; int lat;
    sb_q.push_back('{32'h3FC00000, 1'b0, 1'b0});
    drive_op(32'h3F800000, 32'h3F000000, 1'b0, got, lat);
    e = sb_q.pop_front();
    checks++;
    if (!got || {result, overflow, zero} !== {e.res, e.ovf, e.zro}) begin
      errors++;
      $display("[TB] FAIL b2b_first: done=%b got %h, expected %h", got, result, e.res);
    end
    // Still in the done cycle: raise the next start immediately
    sb_q.push_back('{32'h3F800000, 1'b0, 1'b0});
    op1 = 32'h40000000; op2 = 32'h3F800000; mode = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin got = 1'b1; break; end
      @(negedge clk);
      lat++;
    end
    e = sb_q.pop_front();
    checks++;
    if (!got || lat != 4) begin
      errors++;
      $display("[TB] FAIL b2b_latency: done=%b latency=%0d, expected done=1 latency=4", got, lat);
    end
    checks++;
    if ({result, overflow, zero} !== {e.res, e.ovf, e.zro}) begin
      errors++;
      $display("[TB] FAIL b2b_second: got %h ovf=%b zero=%b, expected %h ovf=%b zero=%b",
               result, overflow, zero, e.res, e.ovf, e.zro);
    end
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    @(negedge clk);
    op1 = 32'h3FA00000; op2 = 32'h3FC00000; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, overflow, zero, result} !== '0) begin
      errors++;
      $display("[TB] FAIL abort_outputs: busy=%b done=%b ovf=%b zero=%b result=%h, expected all 0",
               busy, done, overflow, zero, result);
    end
    for (int i = 0; i < 8; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones != 0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_no_done: got %0d done pulses busy=%b, expected 0 and busy=0",
               dones, busy);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_special();
    test_rounding();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
